// File: rtl/mcu_spi_pkg.sv
// rtl/mcu_spi_pkg.sv - register map, bit indices and engine state type for the SPI peripheral
package mcu_spi_pkg;
  localparam logic [31:0] SPI_BASE = 32'h8000_0000;
  localparam logic [31:0] REG_DATA = 32'h0000_0000;
  localparam logic [31:0] REG_CTRL = 32'h0000_0004;
  localparam int          ADDR_SEL = 2;
  localparam int          BIT_RDY  = 0;
  localparam int          BIT_BUSY = 1;
  localparam int          BIT_SEND = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } spi_state_e;
endpackage

// File: rtl/spi_master_engine.sv
// rtl/spi_master_engine.sv - mode-0 SPI shift engine: divider, bit counter, shift register
module spi_master_engine
  import mcu_spi_pkg::*;
#(
  parameter int SCK_HALF = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx,
  output logic [7:0] rx,
  output logic       busy,
  output logic       done,
  output logic       sck,
  output logic       ss,
  output logic       mosi,
  input  logic       miso
);
  localparam int CW = (SCK_HALF > 2) ? $clog2(SCK_HALF) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(SCK_HALF - 1);

  spi_state_e    r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bits;
  logic [7:0]    r_shift;
  logic          r_sample;
  logic [7:0]    r_rx;
  logic          r_sck;
  logic          r_ss;
  logic          r_mosi;
  logic          w_half_end;

  assign w_half_end = (r_cnt == HALF_LAST);

  // MISO is held in r_sample on the rising edge and enters the shift register LSB
  // on the falling edge, so the outgoing LSB is never overwritten before it is sent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_bits   <= '0;
      r_shift  <= '0;
      r_sample <= 1'b0;
      r_rx     <= '0;
      r_sck    <= 1'b0;
      r_ss     <= 1'b1;
      r_mosi   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shift <= tx;
            r_ss    <= 1'b0;
            r_mosi  <= tx[7];
            r_cnt   <= '0;
            r_bits  <= '0;
            r_state <= ST_LEAD;
          end
        end
        ST_LEAD, ST_LOW: begin
          if (w_half_end) begin
            r_cnt    <= '0;
            r_sck    <= 1'b1;
            r_sample <= miso;
            r_state  <= ST_HIGH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_HIGH: begin
          if (w_half_end) begin
            r_cnt   <= '0;
            r_sck   <= 1'b0;
            r_shift <= {r_shift[6:0], r_sample};
            if (r_bits == 3'd7) begin
              r_state <= ST_DONE;
            end else begin
              r_mosi  <= r_shift[6];
              r_bits  <= r_bits + 1'b1;
              r_state <= ST_LOW;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_rx    <= r_shift;
          r_ss    <= 1'b1;
          r_mosi  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx   = r_rx;
  assign busy = (r_state != ST_IDLE);
  assign done = (r_state == ST_DONE);
  assign sck  = r_sck;
  assign ss   = r_ss;
  assign mosi = r_mosi;
endmodule

// File: rtl/mcu_spi_periph.sv
// rtl/mcu_spi_periph.sv - memory-mapped SPI master: DATA and CTRL/STATUS registers over the engine
module mcu_spi_periph
  import mcu_spi_pkg::*;
#(
  parameter int SCK_HALF = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        sck,
  output logic        ss,
  output logic        mosi,
  input  logic        miso
);
  logic [7:0] r_tx;
  logic       r_start;
  logic       r_rdy;
  logic [7:0] w_rx;
  logic       w_busy;
  logic       w_done;
  logic       w_sel_ctrl;
  logic       w_idle;
  logic       w_wr_data;
  logic       w_send;
  logic       w_rd_data;
  logic       w_unused;

  assign w_sel_ctrl = addr[ADDR_SEL];
  // A SEND accepted this cycle counts as busy until the engine picks it up.
  assign w_idle     = ~w_busy & ~r_start;
  assign w_wr_data  = en & we & ~w_sel_ctrl & w_idle;
  assign w_send     = en & we & w_sel_ctrl & wd[BIT_SEND] & w_idle;
  assign w_rd_data  = en & ~we & ~w_sel_ctrl;
  assign w_unused   = ^{addr[31:3], addr[1:0], wd[31:8]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx    <= '0;
      r_start <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      r_start <= w_send;
      if (w_wr_data) r_tx <= wd[7:0];
      if (w_done) r_rdy <= 1'b1;
      else if (w_send || w_rd_data) r_rdy <= 1'b0;
    end
  end

  always_comb begin
    rd = '0;
    if (w_sel_ctrl) begin
      rd[BIT_BUSY] = w_busy;
      rd[BIT_RDY]  = r_rdy;
    end else begin
      rd[7:0] = w_rx;
    end
  end

  spi_master_engine #(.SCK_HALF(SCK_HALF)) u_engine (
    .clk   (clk),
    .rst   (rst),
    .start (r_start),
    .tx    (r_tx),
    .rx    (w_rx),
    .busy  (w_busy),
    .done  (w_done),
    .sck   (sck),
    .ss    (ss),
    .mosi  (mosi),
    .miso  (miso)
  );
endmodule

// File: tb/tb_mcu_spi_periph.sv
// tb/tb_mcu_spi_periph.sv - randomized self-checking bench with a behavioural SPI slave
module tb_mcu_spi_periph;
  localparam int H    = 4;
  localparam int XFER = 16 * H + 2;

  logic        clk  = 1'b0;
  logic        rst  = 1'b0;
  logic        en   = 1'b0;
  logic        we   = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wd   = '0;
  logic [31:0] rd;
  logic        sck, ss, mosi, miso;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mcu_spi_periph #(.SCK_HALF(H)) dut (
    .clk(clk), .rst(rst), .en(en), .we(we), .addr(addr), .wd(wd),
    .rd(rd), .sck(sck), .ss(ss), .mosi(mosi), .miso(miso)
  );

  // Behavioural mode-0 slave: samples MOSI on SCK rise, advances MISO on SCK fall.
  logic [7:0] sl_tx = '0, sl_out = '0, sl_rx = '0;
  int         sl_pulses = 0;
  logic       ss_q = 1'b1, sck_q = 1'b0;
  assign miso = sl_out[7];

  always @(ss or sck) begin
    if (ss_q === 1'b1 && ss === 1'b0) begin
      sl_out = sl_tx; sl_rx = '0; sl_pulses = 0;
    end else if (ss === 1'b0 && sck === 1'b1 && sck_q === 1'b0) begin
      sl_rx = {sl_rx[6:0], mosi}; sl_pulses++;
    end else if (ss === 1'b0 && sck === 1'b0 && sck_q === 1'b1) begin
      sl_out = {sl_out[6:0], 1'b0};
    end
    ss_q = ss; sck_q = sck;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk); en = 1'b1; we = 1'b1; addr = a; wd = d;
    @(posedge clk); #1; en = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk); en = 1'b1; we = 1'b0; addr = a;
    #1 d = rd;
    @(posedge clk); #1; en = 1'b0;
  endtask

  // mode: 0 plain, 1 DATA+SEND writes while busy, 2 DATA read on the RDY-set cycle, 3 reset abort
  task automatic xfer(input logic [31:0] word, input logic [7:0] slv, input int mode);
    int first_rise = -1, last_high = -1, cycles = 0;
    logic [31:0] ctrl, d;
    ctrl = ($urandom() & ~32'h4) | 32'h4;
    sl_tx = slv;
    bus_write(32'h0, word);
    bus_write(32'h4, ctrl);
    addr = 32'h4;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1; en = 1'b0; we = 1'b0; addr = 32'h4; #1;
      if (k == 1) begin
        check_eq("ss_low_after_send", ss, 0);
        check_eq("busy_after_send", rd[1], 1);
        check_eq("mosi_msb_first", mosi, word[7]);
      end
      if (sck === 1'b1) begin
        if (first_rise < 0) first_rise = k;
        last_high = k;
      end
      if (mode == 3 && sl_pulses == 3 && sck === 1'b1) begin
        rst = 1'b0; #1;
        check_eq("abort_ss", ss, 1);
        check_eq("abort_sck", sck, 0);
        check_eq("abort_mosi", mosi, 0);
        check_eq("abort_status", rd, 0);
        addr = 32'h0; #1;
        check_eq("abort_rx_cleared", rd, 0);
        @(negedge clk); rst = 1'b1;
        return;
      end
      if (rd[0] === 1'b1) begin cycles = k; break; end
      if (mode == 1 && k == 8)  begin en = 1; we = 1; addr = 32'h0; wd = 32'h11; end
      if (mode == 1 && k == 9)  begin en = 1; we = 1; addr = 32'h4; wd = 32'h4; end
      if (mode == 2 && k == XFER - 1) begin en = 1; we = 0; addr = 32'h0; end
    end
    check_eq("xfer_cycles", cycles, XFER);
    check_eq("first_sck_rise", first_rise, H + 1);
    check_eq("last_sck_high", last_high, 16 * H);
    check_eq("ss_idle_after", ss, 1);
    check_eq("slave_rx", sl_rx, word[7:0]);
    check_eq("sck_pulses", sl_pulses, 8);
    bus_read(32'h0, d);
    check_eq("data_read", d, {24'b0, slv});
    bus_read(32'h4, d);
    check_eq("rdy_cleared_by_read", d, 0);
  endtask

  initial begin
    logic [31:0] d, w;
    int t0, guard;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ss", ss, 1);
    check_eq("reset_sck", sck, 0);
    check_eq("reset_mosi", mosi, 0);
    addr = 32'h4; #1 check_eq("reset_status", rd, 0);
    addr = 32'h0; #1 check_eq("reset_data", rd, 0);
    @(negedge clk); rst = 1'b1;

    xfer(32'hDEAD_C0DE, 8'hAA, 0);

    t0 = cyc;
    sl_tx = 8'hAA;
    bus_write(32'h0, 32'hDEAD_C0DE);
    bus_write(32'h4, 32'h4);
    guard = 0;
    do begin bus_read(32'h4, d); guard++; end while (d[1] && guard < 150);
    do begin bus_read(32'h4, d); guard++; end while (!d[0] && guard < 150);
    bus_read(32'h0, d);
    check_eq("cpu_loop_value", d, 32'hAA);
    check_eq("cpu_loop_in_time", (cyc - t0) <= 100, 1);
    check_eq("cpu_loop_slave_rx", sl_rx, 8'hDE);

    xfer(32'h0000_00DE, 8'h3C, 1);
    xfer(32'h0000_0000, 8'hC3, 0);
    xfer(32'h0000_00FF, 8'h00, 0);
    xfer($urandom(), 8'($urandom()), 2);
    for (int i = 0; i < 8; i++) begin
      w = $urandom();
      xfer(w, 8'($urandom()), 0);
    end
    xfer(32'h0000_0042, 8'h81, 0);
    xfer(32'h0000_00A5, 8'h7E, 3);
    xfer(32'h0000_005A, 8'($urandom()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mcu_spi_periph.md
# mcu_spi_periph

Memory-mapped SPI master peripheral of the `mcu`, decoded by the MCU bus at base address 0x8000_0000. The CPU writes a byte to DATA and sets the SEND bit in CTRL/STATUS. The block shifts the byte out MSB-first on MOSI while capturing a byte from MISO, then raises RDY. Software polls BUSY/RDY through 32-bit `lw`/`sw` accesses. The pins connect directly to an external `spi_slave`.

## Interface
- `SCK_HALF`, default 4: system clocks per SCK half-period (≥2).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  bus select; high when the address is in the peripheral window.
- `we`  in  1  write strobe, qualified by `en`.
- `addr`  in  32  byte address; only bit 2 is decoded (0 = DATA, 1 = CTRL/STATUS).
- `wd`  in  32  write data.
- `rd`  out  32  read data; combinational from `addr` and state.
- `sck`  out  1  SPI clock; idles low (mode 0).
- `ss`  out  1  slave select, active low; idles high.
- `mosi`  out  1  master out.
- `miso`  in  1  master in.

## Operation
- DATA (offset 0x0):
  - Write: `tx <= wd[7:0]` when idle. Ignored while BUSY.
  - Read: `{24'b0, rx}`. Reading DATA clears RDY.
- CTRL/STATUS (offset 0x4):
  - Write with `wd[2]` = 1 (SEND) while idle starts a transfer and clears RDY. SEND is ignored while BUSY. Other bits are ignored.
  - Read: `{29'b0, 1'b0, BUSY, RDY}`, i.e. bit1 = BUSY, bit0 = RDY.
- Engine FSM states: IDLE → LEAD → HIGH ⇄ LOW → DONE → IDLE.
  - IDLE: `ss`=1, `sck`=0, `mosi`=0.
  - SEND: load the shift register with `tx`, set `ss`=0, drive `mosi`=`tx[7]`. Enter LEAD.
  - LEAD: after SCK_HALF clocks, set `sck`=1 and sample `miso` into the shift register LSB. Enter HIGH.
  - HIGH: after SCK_HALF clocks, set `sck`=0.
    - If bits remain: shift, put the next MSB on `mosi`, enter LOW.
    - After the 8th bit: enter DONE.
  - LOW: after SCK_HALF clocks, set `sck`=1 and sample. Enter HIGH.
  - DONE: `rx` <= shift register, `ss`=1, BUSY=0, RDY=1. Enter IDLE.
- BUSY = 1 in every state except IDLE.
- A read of DATA in the same cycle RDY is set leaves RDY = 1; set has priority.
- Reset values: `ss`=1, `sck`=0, `mosi`=0, `tx`=0, `rx`=0, BUSY=0, RDY=0, state=IDLE.
- Reset asserted mid-transfer aborts immediately: outputs return to idle values and `rx` is cleared.

## Timing
- SEND written at edge N → `ss`=0, BUSY=1 and MSB on `mosi` from edge N+1.
- First `sck` rise at N+1+SCK_HALF. Each bit lasts 2·SCK_HALF clocks.
- MISO is sampled on the clock edge that raises `sck`. MOSI changes on the edge that lowers `sck`.
- The last `sck` fall occurs at N+1+16·SCK_HALF. `ss`=1, BUSY=0 and RDY=1 follow one clock later.
- Total transfer: 16·SCK_HALF+2 clocks; 66 clocks at the default.
- `rd` reflects a register update in the cycle after the write.

## Structure
- Package `mcu_spi_pkg` holds:
  - Register offsets: DATA=0x0, CTRL=0x4.
  - Bit indices: RDY=0, BUSY=1, SEND=2.
  - Peripheral base 0x8000_0000.
  - FSM state enum.
- Sub-module `spi_master_engine` contains the FSM, divider counter, bit counter and shift register. Its interface is start, tx[7:0], rx[7:0], busy, done and the pins. The top level holds the register file and bus decode.

## Test plan
- Reset: `ss`=1, `sck`=0, `rd` at 0x4 = 0, `rd` at 0x0 = 0.
- Write 0xDEADC0DE to DATA, write 0x4 to CTRL; slave returns 0xAA:
  - Slave receives 0xDE.
  - BUSY reads 1 during the transfer.
  - RDY=1 after 66 clocks.
  - DATA reads 0x0000_00AA.
- Full CPU loop (sw/sw/poll BUSY/poll RDY/lw) finishes within 100 clocks; the CPU register holds 0xAA.
- During BUSY, write DATA=0x11 and SEND again: both ignored; the slave still receives 0xDE and exactly 8 SCK pulses occur.
- Read DATA after RDY: the next STATUS read has RDY=0. Back-to-back transfers of 0x00 then 0xFF are both received correctly.
- Assert `rst` after 3 SCK pulses: `ss`=1, `sck`=0, BUSY=0, RDY=0 immediately. A following transfer of 0x5A succeeds.
